// File: rtl/fc_pkg.sv
// Shared types and default sizing for the fully-connected neuron layer.
// Used by the layer loader and by the neuron layer it fills.
package fc_pkg;

    localparam int FC_SIZE     = 16;
    localparam int FC_LAYER_SZ = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_SETTLE,
        ST_FULL
    } fc_state_e;

endpackage

// File: rtl/fc_layer_loader.sv
// Streams LAYER_SZ input beats into a neuron layer, one write per beat.
// FC_LOADER_AUTOCLEAR_EN adds a one-cycle layer_reset pulse before each fill.
module fc_layer_loader
    import fc_pkg::*;
#(
    parameter int SIZE     = FC_SIZE,
    parameter int LAYER_SZ = FC_LAYER_SZ,
    localparam int ADDR_W  = $clog2(LAYER_SZ)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [SIZE-1:0]   in_data,
    output logic              in_ready,
    output logic              load_en,
    output logic [ADDR_W-1:0] load_address,
    output logic [SIZE-1:0]   load_value,
    output logic              layer_reset,
    output logic              layer_full,
    input  logic              consume,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAYER_SZ - 1);

    fc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              load_en_q, load_en_d;
    logic [ADDR_W-1:0] load_address_q, load_address_d;
    logic [SIZE-1:0]   load_value_q, load_value_d;
    logic              layer_full_q, layer_full_d;
    logic              busy_q, busy_d;
`ifdef FC_LOADER_AUTOCLEAR_EN
    logic              layer_reset_q, layer_reset_d;
`endif

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        load_en_d      = 1'b0;
        load_address_d = load_address_q;
        load_value_d   = load_value_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
`ifdef FC_LOADER_AUTOCLEAR_EN
                    state_d = ST_CLEAR;
`else
                    state_d = ST_LOAD;
`endif
                    cnt_d = '0;
                end
            end
`ifdef FC_LOADER_AUTOCLEAR_EN
            ST_CLEAR: begin
                state_d = ST_LOAD;
                cnt_d   = '0;
            end
`endif
            ST_LOAD: begin
                if (in_valid) begin
                    load_en_d      = 1'b1;
                    load_address_d = cnt_q;
                    load_value_d   = in_data;
                    // The beat at the last address closes the fill; no wrap.
                    if (cnt_q == LAST) begin
                        state_d = ST_SETTLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            ST_SETTLE: state_d = ST_FULL;
            ST_FULL: begin
                if (consume) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        layer_full_d = (state_d == ST_FULL);
        busy_d       = (state_d != ST_IDLE);
`ifdef FC_LOADER_AUTOCLEAR_EN
        layer_reset_d = (state_d == ST_CLEAR);
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            load_en_q      <= 1'b0;
            load_address_q <= '0;
            load_value_q   <= '0;
            layer_full_q   <= 1'b0;
            busy_q         <= 1'b0;
`ifdef FC_LOADER_AUTOCLEAR_EN
            layer_reset_q  <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            load_en_q      <= load_en_d;
            load_address_q <= load_address_d;
            load_value_q   <= load_value_d;
            layer_full_q   <= layer_full_d;
            busy_q         <= busy_d;
`ifdef FC_LOADER_AUTOCLEAR_EN
            layer_reset_q  <= layer_reset_d;
`endif
        end
    end

    assign in_ready     = (state_q == ST_LOAD);
    assign load_en      = load_en_q;
    assign load_address = load_address_q;
    assign load_value   = load_value_q;
    assign layer_full   = layer_full_q;
    assign busy         = busy_q;
`ifdef FC_LOADER_AUTOCLEAR_EN
    assign layer_reset  = layer_reset_q;
`else
    assign layer_reset  = 1'b0;
`endif

endmodule

// File: tb/tb_fc_layer_loader.sv
// Randomized bench for fc_layer_loader with a write-log scoreboard.
// Expected writes, latencies and handshake states come from the bench's own fill model.
`timescale 1ns/1ps
module tb_fc_layer_loader;

    localparam int SIZE = 16;
    localparam int LSZ  = 4;
    localparam int AW   = 2;

    logic            clk;
    logic            reset_n;
    logic            start;
    logic            in_valid;
    logic [SIZE-1:0] in_data;
    logic            in_ready;
    logic            load_en;
    logic [AW-1:0]   load_address;
    logic [SIZE-1:0] load_value;
    logic            layer_reset;
    logic            layer_full;
    logic            consume;
    logic            busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    int mon_addr[$];
    int mon_val[$];
    int mon_cyc[$];

    fc_layer_loader #(
        .SIZE(SIZE),
        .LAYER_SZ(LSZ)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .load_en(load_en),
        .load_address(load_address),
        .load_value(load_value),
        .layer_reset(layer_reset),
        .layer_full(layer_full),
        .consume(consume),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Log every write strobe seen by the neuron layer
    always @(negedge clk) begin
        if (load_en === 1'b1) begin
            mon_addr.push_back(int'(load_address));
            mon_val.push_back(int'(load_value));
            mon_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_log();
        mon_addr.delete();
        mon_val.delete();
        mon_cyc.delete();
    endtask

    // One complete layer fill: start, LAYER_SZ beats with gaps, hold, consume
    task automatic fill(input int gmin, input int gmax, input bit fixed,
                        input bit both);
        int exp_val[$];
        int exp_cyc[$];
        logic [SIZE-1:0] v;
        int g;
        clr_log();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifdef FC_LOADER_AUTOCLEAR_EN
        chk("clear_pulse", 32'(layer_reset), 1);
        chk("clear_rdy", 32'(in_ready), 0);
        chk("clear_busy", 32'(busy), 1);
        @(negedge clk);
        chk("clear_once", 32'(layer_reset), 0);
`else
        chk("no_clear", 32'(layer_reset), 0);
`endif
        for (int i = 0; i < LSZ; i++) begin
            g = int'($urandom_range(gmax, gmin));
            repeat (g) begin
                chk("gap_rdy", 32'(in_ready), 1);
                in_valid = 1'b0;
                in_data  = SIZE'($urandom);
                @(negedge clk);
            end
            chk("beat_rdy", 32'(in_ready), 1);
            v = fixed ? SIZE'(16'h11 * (i + 1)) : SIZE'($urandom);
            in_valid = 1'b1;
            in_data  = v;
            exp_val.push_back(int'(v));
            exp_cyc.push_back(cyc + 1);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = '1;
        consume  = 1'b1;
        chk("settle_rdy", 32'(in_ready), 0);
        chk("settle_full", 32'(layer_full), 0);
        chk("settle_busy", 32'(busy), 1);
        @(negedge clk);
        consume = 1'b0;
        chk("full", 32'(layer_full), 1);
        chk("full_rdy", 32'(in_ready), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("full_hold", 32'(layer_full), 1);
        chk("full_busy", 32'(busy), 1);
        chk("full_no_we", 32'(load_en), 0);
        in_valid = 1'b0;
        chk("n_writes", 32'(mon_addr.size()), LSZ);
        for (int i = 0; i < LSZ && i < mon_addr.size(); i++) begin
            chk("w_addr", 32'(mon_addr[i]), 32'(i));
            chk("w_val", 32'(mon_val[i]), 32'(exp_val[i]));
            chk("w_lat", 32'(mon_cyc[i]), 32'(exp_cyc[i]));
        end
        consume = 1'b1;
        start   = both;
        @(negedge clk);
        consume = 1'b0;
        start   = 1'b0;
        chk("idle_busy", 32'(busy), 0);
        chk("idle_full", 32'(layer_full), 0);
        repeat (3) @(negedge clk);
        chk("stay_idle", 32'(busy), 0);
        chk("stay_rdy", 32'(in_ready), 0);
        chk("no_extra", 32'(mon_addr.size()), LSZ);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"}, 32'(in_ready), 0);
        chk({tag, "_we"}, 32'(load_en), 0);
        chk({tag, "_addr"}, 32'(load_address), 0);
        chk({tag, "_val"}, 32'(load_value), 0);
        chk({tag, "_lrst"}, 32'(layer_reset), 0);
        chk({tag, "_full"}, 32'(layer_full), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        int n0;
        reset_n  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        consume  = 1'b0;
        #1;
        chk_reset_vals("rst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        fill(0, 0, 1'b1, 1'b0);
        fill(3, 3, 1'b1, 1'b0);

        // Abandon a fill after two beats
        clr_log();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifdef FC_LOADER_AUTOCLEAR_EN
        @(negedge clk);
`endif
        repeat (2) begin
            in_valid = 1'b1;
            in_data  = SIZE'($urandom_range(16'hFFFF, 1));
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        n0 = mon_addr.size();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_no_we", 32'(mon_addr.size()), 32'(n0));
        chk("midrst_idle", 32'(busy), 0);

        fill(0, 2, 1'b0, 1'b1);
        repeat (4) fill(0, 3, 1'b0, 1'($urandom_range(1, 0)));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
